// File: rtl/instr_sequencer_pkg.sv
// seq_pkg: shared definitions for the instruction sequencer slice.
//   - default geometry (memory depth, address width, issue divider)
//   - run-controller state encoding, visible on the sequencer 'state' port
//   - instruction class field (instruction[7:6]) and a helper to extract it
package seq_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int AW_DEF    = 4;
    localparam int DIV_DEF   = 4;

    // Encoding is architectural: software and the board display read it.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_BREAK = 3'd4,
        ST_FAULT = 3'd5
    } seq_state_e;

    // Instruction class field, decoded by the datapath.
    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_IMM = 2'b01;
    localparam logic [1:0] OP_MEM = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    function automatic logic [1:0] opcode_of(input logic [7:0] instr);
        return instr[7:6];
    endfunction

endpackage

// File: rtl/instr_sequencer_mem.sv
// instr_mem: DEPTH x 8 program store with synchronous write and a registered
// read port. The array itself is never reset so a program survives RESET;
// only the read register returns to 8'h00.
// Ports:
//   _CLK    system clock
//   RESET   synchronous active-high reset of the read register
//   we      write strobe (already qualified by the sequencer)
//   waddr   write address
//   wdata   write data
//   raddr   read address
//   rd_zero force the read register to 8'h00 (address out of range)
//   rdata   registered read data
module instr_mem
    import seq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          _CLK,
    input  logic          RESET,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    input  logic          rd_zero,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [DEPTH];
    logic [7:0] rdata_r;

    // Program array write port; contents persist across RESET.
    always_ff @(posedge _CLK) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read: old data is returned on the same edge as a write,
    // so a write to the read address shows up one edge later.
    always_ff @(posedge _CLK) begin
        if (RESET) begin
            rdata_r <= 8'h00;
        end else if (rd_zero) begin
            rdata_r <= 8'h00;
        end else begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: run controller for the 8-bit single-cycle datapath.
// Holds the program, presents the instruction at the datapath PC and issues
// one-cycle cpu_en strobes under run / pause / single-step / breakpoint
// control. All outputs are registered.
// Ports:
//   _CLK         system clock, rising edge
//   RESET        synchronous active-high reset, highest priority
//   prog_we      program write strobe (honoured only in IDLE and PAUSE)
//   prog_addr    program write address
//   prog_data    program write data
//   run          start / resume pulse
//   step         single-step pulse
//   halt         pause pulse
//   restart      request a datapath reset pulse and return to IDLE
//   bp_en        breakpoint enable
//   bp_addr      breakpoint PC
//   pc_in        current PC from the datapath
//   instruction  instruction at pc_in, one cycle of latency
//   cpu_en       one-cycle advance strobe to the datapath
//   dp_reset     one-cycle datapath reset
//   state        current controller state encoding
//   fault        high while in FAULT
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DIV   = DIV_DEF
) (
    input  logic          _CLK,
    input  logic          RESET,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic          run,
    input  logic          step,
    input  logic          halt,
    input  logic          restart,
    input  logic          bp_en,
    input  logic [7:0]    bp_addr,
    input  logic [7:0]    pc_in,
    output logic [7:0]    instruction,
    output logic          cpu_en,
    output logic          dp_reset,
    output logic [2:0]    state,
    output logic          fault
);

    localparam int             TW        = $clog2(DIV);
    localparam logic [TW-1:0]  TICK_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0]  TICK_ONE  = TW'(1);
    localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
    localparam logic [8:0]     DEPTH_LIM = 9'(DEPTH);

    seq_state_e    state_r, state_nx_s;
    logic [TW-1:0] tick_r, tick_nx_s;
    // Cycles remaining before another strobe may be issued; keeps back-to-back
    // single steps at least DIV cycles apart.
    logic [TW-1:0] hold_r, hold_nx_s;
    logic          bp_skip_r, bp_skip_nx_s;
    logic          cpu_en_r, cpu_en_nx_s;
    logic          dp_reset_r, dp_reset_nx_s;
    logic          fault_r, fault_nx_s;

    logic          pc_oob_s;
    logic          bp_hit_s;
    logic          mem_we_s;

    assign pc_oob_s = ({1'b0, pc_in} >= DEPTH_LIM);
    assign bp_hit_s = bp_en && (pc_in == bp_addr) && !bp_skip_r;
    assign mem_we_s = prog_we && !RESET &&
                      ((state_r == ST_IDLE) || (state_r == ST_PAUSE));

    instr_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        ._CLK    (_CLK),
        .RESET   (RESET),
        .we      (mem_we_s),
        .waddr   (prog_addr),
        .wdata   (prog_data),
        .raddr   (pc_in[AW-1:0]),
        .rd_zero (pc_oob_s),
        .rdata   (instruction)
    );

    // Next-state, tick, breakpoint-skip and strobe decisions.
    always_comb begin
        state_nx_s    = state_r;
        tick_nx_s     = tick_r;
        bp_skip_nx_s  = bp_skip_r;
        hold_nx_s     = (hold_r != TICK_ZERO) ? (hold_r - TICK_ONE) : hold_r;
        cpu_en_nx_s   = 1'b0;
        dp_reset_nx_s = 1'b0;

        if (restart) begin
            // Restart wins in every state, including FAULT.
            state_nx_s    = ST_IDLE;
            tick_nx_s     = TICK_ZERO;
            bp_skip_nx_s  = 1'b0;
            dp_reset_nx_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_PAUSE, ST_BREAK: begin
                    if (halt) begin
                        state_nx_s = state_r;
                    end else if (run) begin
                        state_nx_s = ST_RUN;
                        tick_nx_s  = TICK_ZERO;
                        // Leaving BREAK must issue the breakpoint PC once.
                        if (state_r == ST_BREAK) begin
                            bp_skip_nx_s = 1'b1;
                        end else begin
                            bp_skip_nx_s = bp_skip_r;
                        end
                    end else if (step) begin
                        state_nx_s = ST_STEP;
                        if (state_r == ST_BREAK) begin
                            bp_skip_nx_s = 1'b1;
                        end else begin
                            bp_skip_nx_s = bp_skip_r;
                        end
                    end else begin
                        state_nx_s = state_r;
                    end
                end

                ST_RUN: begin
                    if (halt) begin
                        // Drops any strobe due this cycle.
                        state_nx_s = ST_PAUSE;
                        tick_nx_s  = TICK_ZERO;
                    end else if (tick_r == TICK_LAST) begin
                        tick_nx_s = TICK_ZERO;
                        if (pc_oob_s) begin
                            state_nx_s = ST_FAULT;
                        end else if (bp_hit_s) begin
                            state_nx_s = ST_BREAK;
                        end else begin
                            cpu_en_nx_s  = 1'b1;
                            bp_skip_nx_s = 1'b0;
                            hold_nx_s    = TICK_LAST;
                        end
                    end else begin
                        tick_nx_s = tick_r + TICK_ONE;
                    end
                end

                ST_STEP: begin
                    // The cycle spent entering STEP lets the instruction
                    // register settle; the issue check happens here.
                    if (halt) begin
                        state_nx_s = ST_PAUSE;
                    end else if (hold_r != TICK_ZERO) begin
                        state_nx_s = ST_STEP;
                    end else if (pc_oob_s) begin
                        state_nx_s = ST_FAULT;
                    end else if (bp_hit_s) begin
                        state_nx_s = ST_BREAK;
                    end else begin
                        state_nx_s   = ST_PAUSE;
                        cpu_en_nx_s  = 1'b1;
                        bp_skip_nx_s = 1'b0;
                        hold_nx_s    = TICK_LAST;
                    end
                end

                ST_FAULT: begin
                    state_nx_s = ST_FAULT;
                end

                default: begin
                    // Unreachable encodings are parked in FAULT.
                    state_nx_s = ST_FAULT;
                    tick_nx_s  = TICK_ZERO;
                end
            endcase
        end

        fault_nx_s = (state_nx_s == ST_FAULT);
    end

    // Controller registers and registered outputs.
    always_ff @(posedge _CLK) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            tick_r     <= TICK_ZERO;
            hold_r     <= TICK_ZERO;
            bp_skip_r  <= 1'b0;
            cpu_en_r   <= 1'b0;
            dp_reset_r <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            tick_r     <= tick_nx_s;
            hold_r     <= hold_nx_s;
            bp_skip_r  <= bp_skip_nx_s;
            cpu_en_r   <= cpu_en_nx_s;
            dp_reset_r <= dp_reset_nx_s;
            fault_r    <= fault_nx_s;
        end
    end

    assign cpu_en   = cpu_en_r;
    assign dp_reset = dp_reset_r;
    assign state    = state_r;
    assign fault    = fault_r;

endmodule
